wb_trace_fifo: RTL and testbench
================================

// Module: wb_trace_fifo
// PURPOSE
// - Sits directly downstream of the 5-stage pipeline's WB stage.
// - Captures every architectural register write (rd != x0) as a trace entry {seq, rd, data}.
// - Buffers entries in a FIFO and hands them to a scoreboard/trace consumer over a valid/ready drain port.
// - Decouples the consumer from pipeline timing; stalls and bubbles (rd = 0) never produce an entry.
// PARAMETERS
// - XLEN   32  data width of a writeback
// - REG_W  5   register index width
// - DEPTH  16  FIFO entries; power of two, >= 2
// - SEQ_W  16  commit sequence counter width
// PORTS
// - clk            in   1      single clock, rising edge
// - reset          in   1      asynchronous, active-low reset
// - wb_we          in   1      WB stage register-write enable
// - wb_rd          in   REG_W  WB destination register index
// - wb_data        in   XLEN   WB write data
// - flush          in   1      synchronous FIFO clear
// - trace_valid    out  1      head entry available
// - trace_ready    in   1      consumer accepts head this cycle
// - trace_rd       out  REG_W  head entry register index
// - trace_data     out  XLEN   head entry data
// - trace_seq      out  SEQ_W  head entry commit sequence number
// - count          out  clog2(DEPTH)+1  occupancy
// - full           out  1      count == DEPTH
// - overflow_cnt   out  16     dropped-entry counter, saturating
// BEHAVIOUR
// - Reset (reset = 0, async): pointers, count, seq counter and overflow_cnt = 0.
// - Reset outputs: trace_valid = 0, full = 0; trace_rd/data/seq = 0.
// - Qualifying commit: wb_we && wb_rd != 0, sampled on the rising clk edge.
// - Seq counter increments by 1 on every qualifying commit, including dropped ones, and wraps at 2^SEQ_W.
//   - A gap in trace_seq therefore identifies lost entries.
// - Entry seq = counter value before the increment. The first commit after reset has seq 0.
// - Push: a qualifying commit when not full, or when full with a pop in the same cycle, is written at wr_ptr.
// - Drop: a qualifying commit when full and no pop; overflow_cnt += 1, saturating at 16'hFFFF.
// - Pop: trace_valid && trace_ready; rd_ptr advances.
// - Outputs are first-word-fall-through.
//   - trace_rd/data/seq = mem[rd_ptr] while trace_valid = (count != 0).
//   - While empty, the head outputs are held at 0.
// - Latency: a push at edge N makes trace_valid = 1 after edge N; there is no same-cycle bypass.
// - Push and pop in the same cycle on an empty FIFO: the pop is impossible (valid = 0) and the push is accepted.
// - Push and pop in the same cycle when full: both occur; count stays DEPTH, no drop.
// - Pointer width = clog2(DEPTH)+1; the MSB distinguishes full from empty on wrap-around.
// - flush = 1: pointers and count cleared at the edge.
//   - A same-cycle commit is discarded, but seq still increments.
//   - seq and overflow_cnt are not cleared.
// - Reset asserted mid-operation: all contents lost immediately. Outputs are at reset values while reset = 0.
// - trace_ready while trace_valid = 0 is ignored.
// STRUCTURE
// - Package wb_trace_pkg:
//   - XLEN, REG_W, SEQ_W constants
//   - typedef struct packed {seq, rd, data} trace_entry_t
// - Sub-module sync_fifo: generic storage and pointers, parameterised on entry type and DEPTH, with push/pop/flush.
// - This block adds commit qualification, seq generation, the drop rule and overflow counting.
// TESTING
// - T1: after reset, commit rd=1 data=32'h12345000, ready=1.
//   - Next cycle: valid=1, rd=1, data=32'h12345000, seq=0.
//   - Following cycle: valid=0.
// - T2: bubble wb_we=1 rd=0 data=32'h5 -> no entry, seq unchanged.
//   - Next commit rd=2 data=3 -> seq=1.
// - T3: ready=0, commit 17 times (rd=1..17, data=i).
//   - full=1, count=16, overflow_cnt=1.
//   - Drain shows seq 0..15; the 18th commit gets seq 17.
// - T4: when full, commit rd=5 with ready=1 in the same cycle.
//   - count stays 16, overflow_cnt unchanged.
//   - Head becomes the old second entry; the new entry is last.
// - T5: 3 entries queued, flush with a same-cycle commit.
//   - Next cycle: valid=0, count=0.
//   - Next commit carries seq = previous seq + 2.
// - T6: reset pulled low mid-drain with 8 entries queued.
//   - valid=0, count=0, overflow_cnt=0 immediately, without waiting for clk.
//   - Next commit gets seq=0.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared constants and the trace entry layout for the writeback trace FIFO.
package wb_trace_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int SEQ_W = 16;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO with push/pop/flush; the head reads as zero while empty.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  T                       i_data,
  output T                       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // Pointers carry one extra bit so full and empty differ after wrap-around.
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  T            r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_count   = r_wr - r_rd;
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (o_count == FULL_CNT);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_comb begin
    o_data = '0;
    if (!o_empty) o_data = r_mem[r_rd[AW-1:0]];
  end

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures architectural register writes leaving WB as sequenced trace entries
// and buffers them for a valid/ready consumer; drops are counted, never stalled.
module wb_trace_fifo
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_we,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [REG_W-1:0]       trace_rd,
  output logic [XLEN-1:0]        trace_data,
  output logic [SEQ_W-1:0]       trace_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic [15:0]            overflow_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [SEQ_W-1:0] r_seq;
  logic [15:0]      r_ovf;
  logic             w_commit;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_empty;
  trace_entry_t     w_in;
  trace_entry_t     w_head;

  assign w_commit = wb_we && (wb_rd != '0);
  assign w_pop    = trace_valid && trace_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign w_push   = w_commit && !flush && (!full || w_pop);
  assign w_drop   = w_commit && !flush && full && !w_pop;

  assign w_in = '{seq: r_seq, rd: wb_rd, data: wb_data};

  sync_fifo #(
    .T     (trace_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (full),
    .o_count (count)
  );

  // Sequence advances on every qualifying commit so gaps expose lost entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seq <= '0;
      r_ovf <= '0;
    end else begin
      if (w_commit) r_seq <= r_seq + 1'b1;
      if (w_drop)   r_ovf <= sat_inc(r_ovf);
    end
  end

  assign trace_valid  = !w_empty;
  assign trace_rd     = w_head.rd;
  assign trace_data   = w_head.data;
  assign trace_seq    = w_head.seq;
  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomised scoreboard bench for wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [15:0] trace_seq;
  logic [4:0]  count;
  logic        full;
  logic [15:0] overflow_cnt;

  wb_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .flush        (flush),
    .trace_valid  (trace_valid),
    .trace_ready  (trace_ready),
    .trace_rd     (trace_rd),
    .trace_data   (trace_data),
    .trace_seq    (trace_seq),
    .count        (count),
    .full         (full),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [15:0] seq;
  } ent_t;

  ent_t        exp_q[$];
  int          m_cnt = 0;
  logic [15:0] m_seq = '0;
  logic [15:0] m_ovf = '0;
  int          checks = 0;
  int          failures = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: applies the rules for one clock edge to the expected queue.
  task automatic model_step();
    bit   commit;
    bit   pop;
    ent_t e;
    commit = wb_we && (wb_rd != 0);
    pop    = trace_ready && (m_cnt > 0);
    if (flush) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (commit && (m_cnt < DEPTH || pop)) begin
        e.rd = wb_rd; e.data = wb_data; e.seq = m_seq;
        exp_q.push_back(e);
        m_cnt = m_cnt + 1 - int'(pop);
      end else begin
        if (commit && m_ovf != 16'hFFFF) m_ovf++;
        m_cnt = m_cnt - int'(pop);
      end
    end
    if (commit) m_seq++;
  endtask

  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                      input logic rdy, input logic fl);
    wb_we = we; wb_rd = rd; wb_data = d; trace_ready = rdy; flush = fl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  // Monitor: compares the DUT head/status against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("valid", trace_valid, exp_q.size() != 0);
      chk("count", count, m_cnt);
      chk("full", full, m_cnt == DEPTH);
      chk("overflow_cnt", overflow_cnt, m_ovf);
      if (trace_valid && exp_q.size() != 0) begin
        chk("head_rd", trace_rd, exp_q[0].rd);
        chk("head_data", trace_data, exp_q[0].data);
        chk("head_seq", trace_seq, exp_q[0].seq);
        if (trace_ready) void'(exp_q.pop_front());
      end else if (!trace_valid) begin
        chk("empty_head", {trace_rd, trace_data, trace_seq}, 64'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, trace_valid, 1'b0);
    chk({tag, "_count"}, count, 5'd0);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_ovf"}, overflow_cnt, 16'd0);
    chk({tag, "_head"}, {trace_rd, trace_data, trace_seq}, 64'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    m_cnt = 0; m_seq = '0; m_ovf = '0;
    #1;
    check_reset_outputs("async_reset");
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; trace_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    reset = 1'b1;

    // T1: single commit, one-cycle latency, then drained
    step(1'b1, 5'd1, 32'h12345000, 1'b1, 1'b0);
    idle(1'b1, 2);

    // T2: bubble produces nothing; next commit gets seq 1
    step(1'b1, 5'd0, 32'h5, 1'b1, 1'b0);
    step(1'b1, 5'd2, 32'd3, 1'b1, 1'b0);
    idle(1'b1, 2);

    // T3: fill past full with consumer stalled, then drain and commit once more
    apply_reset();
    for (int i = 1; i <= 17; i++) step(1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("t3_full", full, 1'b1);
    chk("t3_ovf", overflow_cnt, 16'd1);
    idle(1'b1, 17);
    step(1'b1, 5'd18, 32'd18, 1'b1, 1'b0);
    idle(1'b1, 2);

    // T4: commit and pop together while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 5'd5, 32'hBEEF, 1'b1, 1'b0);
    idle(1'b0, 1);
    chk("t4_count", count, 5'd16);
    idle(1'b1, 18);

    // T5: flush with a same-cycle commit
    for (int i = 0; i < 3; i++) step(1'b1, 5'd7, 32'(i), 1'b0, 1'b0);
    step(1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
    idle(1'b0, 1);
    step(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
    idle(1'b1, 2);

    // T6: asynchronous reset in the middle of a drain
    for (int i = 0; i < 8; i++) step(1'b1, 5'd10, 32'hC0 + 32'(i), 1'b0, 1'b0);
    idle(1'b1, 2);
    #2;
    apply_reset();
    step(1'b1, 5'd3, 32'h33, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Random traffic with bursty consumer
    for (int i = 0; i < 3000; i++) begin
      logic        we, rdy, fl;
      logic [4:0]  rd;
      logic [31:0] d;
      we  = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      d   = $urandom;
      rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 99) == 0);
      step(we, rd, d, rdy, fl);
    end
    idle(1'b1, DEPTH + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
